// File: rtl/ebus_mapper.sv
// Z80 external-bus memory mapper: banked address windows, bank/control
// registers at the top of memory, strobe synchronisers and RAM strobes.
module ebus_mapper #(
    parameter int          SLOT_BITS = 2,
    parameter int          BANK_W    = 5,
    parameter logic [15:0] LOW_FIXED = 16'h0400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       ebus_a,
    input  logic [7:0]        ebus_d,
    input  logic              ebus_rd_n,
    input  logic              ebus_wr_n,
    input  logic              ebus_mreq_n,
    output logic [BANK_W-1:0] ebus_ba,
    output logic              ebus_ram_ce_n,
    output logic              ebus_ram_we_n,
    input  logic              sel_internal,
    output logic [7:0]        wrdata,
    output logic              bus_read,
    output logic              bus_write,
    output logic              bus_read_done,
    output logic              bus_write_done,
    output logic              startup_mode,
    output logic [7:0]        ramctrl,
    output logic              reg_rd_sel,
    output logic [7:0]        reg_rddata
);

    localparam int W  = 1 << SLOT_BITS;
    localparam int NB = W - 1;

    logic [2:0]        s_wr_q;
    logic [2:0]        s_rd_q;
    logic [7:0]        wrdata_q;
    logic [7:0]        ramctrl_q;
    logic              startup_q;
    logic [BANK_W-1:0] bank_q [NB];

    logic [SLOT_BITS-1:0] win;
    logic [SLOT_BITS-1:0] off;
    logic                 reg_hit;
    logic                 reg_wr;
    logic                 ram_sel;
    logic                 wr_en;
    logic [BANK_W-1:0]    ba_d;
    logic [7:0]           rddata_d;

    assign win     = ebus_a[15 -: SLOT_BITS];
    assign off     = ebus_a[SLOT_BITS-1:0];
    assign reg_hit = &ebus_a[15:SLOT_BITS];

    // s[0] is the newest sample; a pulse marks the level change reaching s[1].
    always_ff @(posedge clk) begin
        if (reset) begin
            s_wr_q <= 3'b111;
            s_rd_q <= 3'b111;
        end else begin
            s_wr_q <= {s_wr_q[1:0], ebus_wr_n};
            s_rd_q <= {s_rd_q[1:0], ebus_rd_n};
        end
    end

    assign bus_write      =  s_wr_q[2] & ~s_wr_q[1];
    assign bus_write_done = ~s_wr_q[2] &  s_wr_q[1];
    assign bus_read       =  s_rd_q[2] & ~s_rd_q[1];
    assign bus_read_done  = ~s_rd_q[2] &  s_rd_q[1];

    assign reg_wr = bus_write & ~ebus_mreq_n & reg_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            wrdata_q  <= 8'h00;
            ramctrl_q <= 8'h00;
            startup_q <= 1'b1;
            for (int i = 0; i < NB; i++) begin
                bank_q[i] <= BANK_W'(i);
            end
        end else begin
            if (!ebus_wr_n) begin
                wrdata_q <= ebus_d;
            end
            if (reg_wr && off == '0) begin
                ramctrl_q <= wrdata_q;
                startup_q <= 1'b0;
            end
            for (int i = 0; i < NB; i++) begin
                if (reg_wr && off == SLOT_BITS'(i + 1)) begin
                    bank_q[i] <= wrdata_q[BANK_W-1:0];
                end
            end
        end
    end

    always_comb begin
        ba_d     = '0;
        wr_en    = startup_q;
        rddata_d = ramctrl_q;
        for (int i = 0; i < NB; i++) begin
            if (win == SLOT_BITS'(i)) begin
                ba_d = bank_q[i];
                if (ramctrl_q[i]) begin
                    wr_en = 1'b1;
                end
            end
            if (off == SLOT_BITS'(i + 1)) begin
                rddata_d = 8'(bank_q[i]);
            end
        end
        // The bottom of window 0 is pinned to bank 0 regardless of bank0.
        if (win == '0 && ebus_a < LOW_FIXED) begin
            ba_d = '0;
        end
    end

    assign ram_sel       = ~ebus_mreq_n & ~sel_internal;
    assign ebus_ram_ce_n = ~(ram_sel & (~ebus_rd_n | (~ebus_wr_n & wr_en)));
    assign ebus_ram_we_n = ~(~ebus_wr_n & wr_en & ram_sel);

    assign ebus_ba      = ba_d;
    assign wrdata       = wrdata_q;
    assign ramctrl      = ramctrl_q;
    assign startup_mode = startup_q;
    assign reg_rd_sel   = ~ebus_mreq_n & ~ebus_rd_n & reg_hit;
    assign reg_rddata   = rddata_d;

endmodule

// File: tb/tb_ebus_mapper.sv
// Directed bench for ebus_mapper: a 4-window and an 8-window instance
// share one Z80 bus.
module tb_ebus_mapper;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ebus_a;
    logic [7:0]  ebus_d;
    logic        ebus_rd_n, ebus_wr_n, ebus_mreq_n;
    logic        sel_internal;

    logic [4:0] ba;
    logic       ce_n, we_n;
    logic [7:0] wrdata, ramctrl, rddata;
    logic       brd, bwr, brd_done, bwr_done, startup, rsel;

    logic [4:0] b_ba;
    logic       b_ce_n, b_we_n;
    logic [7:0] b_wrdata, b_ramctrl, b_rddata;
    logic       b_brd, b_bwr, b_brd_done, b_bwr_done, b_startup, b_rsel;

    int checks = 0;
    int errors = 0;
    int nw = 0;
    int nwd = 0;
    int nw0, nwd0;

    always #5 clk = ~clk;

    ebus_mapper dut (
        .clk(clk), .reset(reset), .ebus_a(ebus_a), .ebus_d(ebus_d),
        .ebus_rd_n(ebus_rd_n), .ebus_wr_n(ebus_wr_n),
        .ebus_mreq_n(ebus_mreq_n), .ebus_ba(ba),
        .ebus_ram_ce_n(ce_n), .ebus_ram_we_n(we_n),
        .sel_internal(sel_internal), .wrdata(wrdata),
        .bus_read(brd), .bus_write(bwr), .bus_read_done(brd_done),
        .bus_write_done(bwr_done), .startup_mode(startup),
        .ramctrl(ramctrl), .reg_rd_sel(rsel), .reg_rddata(rddata)
    );

    ebus_mapper #(.SLOT_BITS(3)) dut8 (
        .clk(clk), .reset(reset), .ebus_a(ebus_a), .ebus_d(ebus_d),
        .ebus_rd_n(ebus_rd_n), .ebus_wr_n(ebus_wr_n),
        .ebus_mreq_n(ebus_mreq_n), .ebus_ba(b_ba),
        .ebus_ram_ce_n(b_ce_n), .ebus_ram_we_n(b_we_n),
        .sel_internal(sel_internal), .wrdata(b_wrdata),
        .bus_read(b_brd), .bus_write(b_bwr), .bus_read_done(b_brd_done),
        .bus_write_done(b_bwr_done), .startup_mode(b_startup),
        .ramctrl(b_ramctrl), .reg_rd_sel(b_rsel), .reg_rddata(b_rddata)
    );

    always @(negedge clk) begin
        if (bwr === 1'b1) nw <= nw + 1;
        if (bwr_done === 1'b1) nwd <= nwd + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ebus_mreq_n = 1'b1;
        ebus_rd_n   = 1'b1;
        ebus_wr_n   = 1'b1;
        #1;
    endtask

    task automatic rd(input logic [15:0] a);
        ebus_a      = a;
        ebus_wr_n   = 1'b1;
        ebus_mreq_n = 1'b0;
        ebus_rd_n   = 1'b0;
        #1;
    endtask

    // Write strobe held within one clock period, never sampled by an edge.
    task automatic wr_peek(input logic [15:0] a, input logic mreq_n);
        ebus_a      = a;
        ebus_rd_n   = 1'b1;
        ebus_mreq_n = mreq_n;
        ebus_wr_n   = 1'b0;
        #1;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        ebus_a      = a;
        ebus_d      = d;
        ebus_rd_n   = 1'b1;
        ebus_mreq_n = 1'b0;
        ebus_wr_n   = 1'b0;
        repeat (5) tick();
        ebus_wr_n = 1'b1;
        repeat (4) tick();
        ebus_mreq_n = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        ebus_a = 16'h0000;
        ebus_d = 8'h00;
        ebus_rd_n = 1'b1;
        ebus_wr_n = 1'b1;
        ebus_mreq_n = 1'b1;
        sel_internal = 1'b0;
        repeat (3) tick();

        chk("rst_startup", startup, 1);
        chk("rst_ramctrl", ramctrl, 0);
        chk("rst_wrdata", wrdata, 0);
        chk("rst_bwr", bwr, 0);
        chk("rst_brd_done", brd_done, 0);
        rd(16'hFFFD); chk("rst_bank0", rddata, 0);
        rd(16'hFFFE); chk("rst_bank1", rddata, 1);
        rd(16'hFFFF); chk("rst_bank2", rddata, 2);
        idle();
        reset = 1'b0;
        tick();

        rd(16'h4123);
        chk("rd4123_ba", ba, 1);
        chk("rd4123_ce", ce_n, 0);
        chk("rd4123_we", we_n, 1);
        rd(16'h0123); chk("rd0123_ba", ba, 0);
        rd(16'h0523); chk("rd0523_ba", ba, 0);
        rd(16'hC000);
        chk("rdC000_ba", ba, 0);
        chk("rdC000_rsel", rsel, 0);
        sel_internal = 1'b1;
        rd(16'h4123); chk("selint_ce", ce_n, 1);
        sel_internal = 1'b0;
        idle();
        tick();

        bus_wr(16'hFFFD, 8'h03);
        rd(16'h0523); chk("bank0_0523", ba, 3);
        rd(16'h03FF); chk("low_fixed_03FF", ba, 0);
        rd(16'h0400); chk("low_fixed_0400", ba, 3);
        idle();
        tick();

        bus_wr(16'hFFFE, 8'h07);
        rd(16'h4000); chk("bank1_ba", ba, 7);
        rd(16'hFFFE);
        chk("rd_FFFE_sel", rsel, 1);
        chk("rd_FFFE_data", rddata, 8'h07);
        idle();
        chk("idle_rsel", rsel, 0);
        wr_peek(16'h4000, 1'b0);
        chk("startup_wr_ce", ce_n, 0);
        chk("startup_wr_we", we_n, 0);
        idle();
        tick();

        // Bit 2 enables writes to window 2 only.
        bus_wr(16'hFFFC, 8'h04);
        chk("ctrl_startup", startup, 0);
        chk("ctrl_ramctrl", ramctrl, 8'h04);
        chk("ctrl_wrdata", wrdata, 8'h04);
        wr_peek(16'h8000, 1'b0);
        chk("wr8000_ce", ce_n, 0);
        chk("wr8000_we", we_n, 0);
        wr_peek(16'h4000, 1'b0);
        chk("wr4000_ce", ce_n, 1);
        chk("wr4000_we", we_n, 1);
        wr_peek(16'h8000, 1'b1);
        chk("wr_nomreq_ce", ce_n, 1);
        chk("wr_nomreq_we", we_n, 1);
        rd(16'h4000); chk("rd4000_ce", ce_n, 0);
        idle();
        tick();

        nw0 = nw;
        ebus_wr_n = 1'b0;
        tick(); chk("bwr_edge1", bwr, 0);
        tick(); chk("bwr_edge2", bwr, 1);
        tick(); chk("bwr_edge3", bwr, 0);
        repeat (7) tick();
        chk("bwr_count", 16'(nw - nw0), 1);
        nwd0 = nwd;
        ebus_wr_n = 1'b1;
        tick(); chk("bwd_edge1", bwr_done, 0);
        tick(); chk("bwd_edge2", bwr_done, 1);
        repeat (4) tick();
        chk("bwd_count", 16'(nwd - nwd0), 1);
        chk("bwr_count2", 16'(nw - nw0), 1);
        chk("no_reg_wr_nomreq", startup, 0);

        ebus_a = 16'h8000;
        ebus_d = 8'h55;
        ebus_mreq_n = 1'b0;
        ebus_wr_n = 1'b0;
        repeat (4) tick();
        nwd0 = nwd;
        reset = 1'b1;
        tick();
        chk("midrst_startup", startup, 1);
        chk("midrst_bwr", bwr, 0);
        idle();
        repeat (4) tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("midrst_no_done", 16'(nwd - nwd0), 0);
        chk("midrst_wrdata", wrdata, 0);
        chk("midrst_ramctrl", ramctrl, 0);
        rd(16'hFFFD); chk("midrst_bank0", rddata, 0);
        rd(16'hFFFE); chk("midrst_bank1", rddata, 1);
        rd(16'hFFFF); chk("midrst_bank2", rddata, 2);
        rd(16'hFFFC); chk("midrst_ctrl", rddata, 0);
        idle();
        tick();

        bus_wr(16'hFFFA, 8'h0A);
        rd(16'h2000);
        chk("s3_ba_2000", b_ba, 5'h0A);
        chk("s2_ba_2000", ba, 0);
        rd(16'hFFFA);
        chk("s3_rsel_FFFA", b_rsel, 1);
        chk("s3_data_FFFA", b_rddata, 8'h0A);
        chk("s2_rsel_FFFA", rsel, 0);
        rd(16'hFFF8);
        chk("s3_ctrl", b_rddata, 0);
        chk("s3_startup", b_startup, 1);
        rd(16'hFFF9); chk("s3_bank0", b_rddata, 0);
        rd(16'hFFF7); chk("s3_rsel_FFF7", b_rsel, 0);
        rd(16'hE000); chk("s3_ba_E000", b_ba, 0);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
